// File: rtl/race_checker_pkg.sv
// Shared types for the race checker: FSM states, tolerance modes and a saturating counter helper.
package race_checker_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PASS = 2'd2,
        FAIL = 2'd3
    } state_t;

    typedef enum logic {
        STRICT = 1'b0,
        SKEW   = 1'b1
    } mode_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/race_channel.sv
// One counter pair: counts both producers, tracks inc_a events toward completion and
// flags when the modular difference between the counters exceeds the tolerance.
module race_channel
    import race_checker_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int NUM_TESTS = 100
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             run,
    input  logic             inc_a,
    input  logic             inc_b,
    input  logic [WIDTH-1:0] tol,
    output logic             viol,
    output logic             complete
);

    localparam int EVW = $clog2(NUM_TESTS + 1);

    logic [WIDTH-1:0] cnt_a_q, cnt_a_d;
    logic [WIDTH-1:0] cnt_b_q, cnt_b_d;
    logic [EVW-1:0]   ev_q, ev_d;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] mag;

    always_comb begin
        cnt_a_d = cnt_a_q;
        cnt_b_d = cnt_b_q;
        ev_d    = ev_q;
        if (clear) begin
            cnt_a_d = '0;
            cnt_b_d = '0;
            ev_d    = '0;
        end else if (run) begin
            if (inc_a) cnt_a_d = cnt_a_q + WIDTH'(1);
            if (inc_b) cnt_b_d = cnt_b_q + WIDTH'(1);
            if (inc_a && (ev_q != EVW'(NUM_TESTS))) ev_d = ev_q + EVW'(1);
        end
    end

    // Modular subtraction keeps wrap-around of either counter from looking like a race;
    // the most negative difference maps to 2^(WIDTH-1), which always exceeds tol.
    always_comb begin
        diff     = cnt_a_q - cnt_b_q;
        mag      = diff[WIDTH-1] ? (~diff + WIDTH'(1)) : diff;
        viol     = run && (mag > tol);
        complete = (ev_q == EVW'(NUM_TESTS));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_a_q <= '0;
            cnt_b_q <= '0;
            ev_q    <= '0;
        end else begin
            cnt_a_q <= cnt_a_d;
            cnt_b_q <= cnt_b_d;
            ev_q    <= ev_d;
        end
    end

endmodule

// File: rtl/race_checker.sv
// Checks that two producers increment NUM_CH counter pairs in lock-step (or within a skew),
// reporting PASS after NUM_TESTS events per channel or FAIL on the first violation.
module race_checker
    import race_checker_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int WIDTH     = 8,
    parameter int NUM_TESTS = 100,
    parameter int MAX_SKEW  = 1
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         start,
    input  logic                                         mode,
    input  logic [NUM_CH-1:0]                            inc_a,
    input  logic [NUM_CH-1:0]                            inc_b,
    output logic                                         busy,
    output logic                                         done,
    output logic                                         fail,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] fail_ch,
    output logic [15:0]                                  err_count
);

    localparam int FCW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    state_t           state_q, state_d;
    mode_t            mode_q, mode_d;
    logic [FCW-1:0]   fail_ch_q, fail_ch_d;
    logic [15:0]      err_count_q, err_count_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             fail_q, fail_d;
    logic [FCW-1:0]   first_idx;
    logic [NUM_CH-1:0] viol_vec;
    logic [NUM_CH-1:0] complete_vec;
    logic [WIDTH-1:0] tol;
    logic             run;

    assign run = (state_q == RUN);
    assign tol = (mode_q == SKEW) ? WIDTH'(MAX_SKEW) : '0;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        race_channel #(
            .WIDTH     (WIDTH),
            .NUM_TESTS (NUM_TESTS)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .clear    (start),
            .run      (run),
            .inc_a    (inc_a[gi]),
            .inc_b    (inc_b[gi]),
            .tol      (tol),
            .viol     (viol_vec[gi]),
            .complete (complete_vec[gi])
        );
    end

    // Violation is checked before completion so a race in the finishing cycle still fails.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        fail_ch_d   = fail_ch_q;
        err_count_d = err_count_q;
        first_idx   = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (viol_vec[i]) first_idx = FCW'(i);
        end
        if (start) begin
            state_d     = RUN;
            mode_d      = mode_t'(mode);
            fail_ch_d   = '0;
            err_count_d = '0;
        end else if (state_q == RUN) begin
            if (|viol_vec) begin
                state_d     = FAIL;
                fail_ch_d   = first_idx;
                err_count_d = sat_inc16(err_count_q);
            end else if (&complete_vec) begin
                state_d = PASS;
            end
        end
        busy_d = (state_d == RUN);
        done_d = (state_d == PASS);
        fail_d = (state_d == FAIL);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mode_q      <= STRICT;
            fail_ch_q   <= '0;
            err_count_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            fail_ch_q   <= fail_ch_d;
            err_count_q <= err_count_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            fail_q      <= fail_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign fail      = fail_q;
    assign fail_ch   = fail_ch_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_race_checker.sv
// Directed self-checking bench for race_checker: default build plus a 4-bit, 40-event build
// to exercise counter wrap-around.
module tb_race_checker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, mode;
    logic [3:0]  inc_a, inc_b;
    logic        busy, done, fail;
    logic [1:0]  fail_ch;
    logic [15:0] err_count;

    logic        start2, mode2;
    logic [3:0]  inc_a2, inc_b2;
    logic        busy2, done2, fail2;
    logic [1:0]  fail_ch2;
    logic [15:0] err_count2;

    int n_vec  = 0;
    int n_miss = 0;

    logic [3:0] va, vb;

    always #5 clk = ~clk;

    race_checker #(.NUM_CH(4), .WIDTH(8), .NUM_TESTS(100), .MAX_SKEW(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .inc_a(inc_a), .inc_b(inc_b), .busy(busy), .done(done), .fail(fail),
        .fail_ch(fail_ch), .err_count(err_count)
    );

    race_checker #(.NUM_CH(4), .WIDTH(4), .NUM_TESTS(40), .MAX_SKEW(1)) dut_w4 (
        .clk(clk), .rst_n(rst_n), .start(start2), .mode(mode2),
        .inc_a(inc_a2), .inc_b(inc_b2), .busy(busy2), .done(done2), .fail(fail2),
        .fail_ch(fail_ch2), .err_count(err_count2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic st, input logic md,
                                 input logic [3:0] a, input logic [3:0] b);
        start = st;
        mode  = md;
        inc_a = a;
        inc_b = b;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkState(input string tag, input logic b, input logic d, input logic f);
        checkOutput({tag, ".busy"}, 32'(busy), 32'(b));
        checkOutput({tag, ".done"}, 32'(done), 32'(d));
        checkOutput({tag, ".fail"}, 32'(fail), 32'(f));
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 4'h0, 4'h0);
        start2 = 1'b0; mode2 = 1'b0; inc_a2 = 4'h0; inc_b2 = 4'h0;
        tick();
        tick();
        checkState("reset", 1'b0, 1'b0, 1'b0);
        checkOutput("reset.fail_ch", 32'(fail_ch), 0);
        checkOutput("reset.err_count", 32'(err_count), 0);
        checkOutput("reset.w4_busy", 32'(busy2), 0);
        rst_n = 1'b1;
        tick();
        checkState("idle", 1'b0, 1'b0, 1'b0);

        // Strict, all channels matched for 100 cycles
        applyStimulus(1'b1, 1'b0, 4'h0, 4'h0);
        tick();
        checkState("strict_start", 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'hF, 4'hF);
        repeat (100) tick();
        checkState("strict_100", 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'h0, 4'h0);
        tick();
        checkState("strict_pass", 1'b0, 1'b1, 1'b0);
        checkOutput("strict_pass.err_count", 32'(err_count), 0);
        applyStimulus(1'b0, 1'b1, 4'h5, 4'h0);
        repeat (3) tick();
        checkState("pass_hold", 1'b0, 1'b1, 1'b0);
        checkOutput("pass_hold.err_count", 32'(err_count), 0);

        // Strict, channel 2 producer B one cycle late
        applyStimulus(1'b1, 1'b0, 4'h0, 4'h0);
        tick();
        checkState("lag1_start", 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'hF, 4'hF);
        repeat (3) tick();
        applyStimulus(1'b0, 1'b0, 4'hF, 4'hB);
        tick();
        checkState("lag1_mismatch", 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'hF, 4'hF);
        tick();
        checkState("lag1_fail", 1'b0, 1'b0, 1'b1);
        checkOutput("lag1.fail_ch", 32'(fail_ch), 2);
        checkOutput("lag1.err_count", 32'(err_count), 1);
        applyStimulus(1'b0, 1'b0, 4'h0, 4'h4);
        repeat (2) tick();
        checkState("fail_hold", 1'b0, 1'b0, 1'b1);
        checkOutput("fail_hold.fail_ch", 32'(fail_ch), 2);
        checkOutput("fail_hold.err_count", 32'(err_count), 1);

        // Skew mode, same one-cycle lag must pass; mode is dropped after start
        applyStimulus(1'b1, 1'b1, 4'h0, 4'h0);
        tick();
        checkState("skew_start", 1'b1, 1'b0, 1'b0);
        checkOutput("skew_start.err_count", 32'(err_count), 0);
        checkOutput("skew_start.fail_ch", 32'(fail_ch), 0);
        for (int i = 0; i <= 100; i++) begin
            va = (i < 100) ? 4'hF : 4'h0;
            vb = ((i < 100) ? 4'hB : 4'h0) | ((i >= 1) ? 4'h4 : 4'h0);
            applyStimulus(1'b0, 1'b0, va, vb);
            tick();
            if (i == 50) checkState("skew_mid", 1'b1, 1'b0, 1'b0);
        end
        checkState("skew_pass", 1'b0, 1'b1, 1'b0);
        checkOutput("skew_pass.err_count", 32'(err_count), 0);

        // Skew mode, two-cycle lag on channel 2
        applyStimulus(1'b1, 1'b1, 4'h0, 4'h0);
        tick();
        applyStimulus(1'b0, 1'b1, 4'hF, 4'hB);
        tick();
        checkState("lag2_d1", 1'b1, 1'b0, 1'b0);
        tick();
        checkState("lag2_d2", 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 4'hF, 4'hF);
        tick();
        checkState("lag2_fail", 1'b0, 1'b0, 1'b1);
        checkOutput("lag2.fail_ch", 32'(fail_ch), 2);
        checkOutput("lag2.err_count", 32'(err_count), 1);

        // Reset mid-run with coincident start, then a fresh run
        applyStimulus(1'b1, 1'b0, 4'h0, 4'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 4'hF, 4'hF);
        repeat (10) tick();
        checkState("pre_reset", 1'b1, 1'b0, 1'b0);
        rst_n = 1'b0;
        applyStimulus(1'b1, 1'b0, 4'h0, 4'h0);
        tick();
        checkState("in_reset", 1'b0, 1'b0, 1'b0);
        checkOutput("in_reset.err_count", 32'(err_count), 0);
        checkOutput("in_reset.fail_ch", 32'(fail_ch), 0);
        applyStimulus(1'b0, 1'b0, 4'h0, 4'h0);
        tick();
        rst_n = 1'b1;
        tick();
        checkState("post_reset", 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 4'h0, 4'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 4'hF, 4'hF);
        repeat (99) tick();
        checkState("fresh_99", 1'b1, 1'b0, 1'b0);
        tick();
        checkState("fresh_100", 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'h0, 4'h0);
        tick();
        checkState("fresh_pass", 1'b0, 1'b1, 1'b0);
        checkOutput("fresh_pass.err_count", 32'(err_count), 0);

        // Violations on channels 1 and 3 in the completing cycle
        applyStimulus(1'b1, 1'b0, 4'h0, 4'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 4'hF, 4'hF);
        repeat (99) tick();
        applyStimulus(1'b0, 1'b0, 4'hF, 4'h5);
        tick();
        checkState("both_pre", 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'h0, 4'h0);
        tick();
        checkState("both_fail", 1'b0, 1'b0, 1'b1);
        checkOutput("both.fail_ch", 32'(fail_ch), 1);
        checkOutput("both.err_count", 32'(err_count), 1);

        // 4-bit counters, 40 matched events: counters wrap twice
        start2 = 1'b1; mode2 = 1'b0;
        tick();
        start2 = 1'b0; inc_a2 = 4'hF; inc_b2 = 4'hF;
        repeat (40) tick();
        checkOutput("w4.busy_40", 32'(busy2), 1);
        inc_a2 = 4'h0; inc_b2 = 4'h0;
        tick();
        checkOutput("w4.done", 32'(done2), 1);
        checkOutput("w4.fail", 32'(fail2), 0);
        checkOutput("w4.err_count", 32'(err_count2), 0);

        // 4-bit skew run with a one-cycle lag straddling the wrap on channel 0
        start2 = 1'b1; mode2 = 1'b1;
        tick();
        start2 = 1'b0; mode2 = 1'b0; inc_a2 = 4'hF; inc_b2 = 4'hF;
        repeat (15) tick();
        inc_b2 = 4'hE;
        tick();
        checkOutput("w4skew.busy_wrap", 32'(busy2), 1);
        inc_b2 = 4'hF;
        repeat (24) tick();
        checkOutput("w4skew.fail_24", 32'(fail2), 0);
        inc_a2 = 4'h0; inc_b2 = 4'h1;
        tick();
        checkOutput("w4skew.done", 32'(done2), 1);
        checkOutput("w4skew.err_count", 32'(err_count2), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
